// File: rtl/cpu_types_pkg.sv
// ----------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the multicore memory system.
//   word_t      : 32-bit data/address word
//   ramstate_t  : status reported by the RAM model (FREE, BUSY, ACCESS, ERROR)
//   arb_state_t : ram_arbiter control state (IDLE, OWN)
// ----------------------------------------------------------------------------
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// ----------------------------------------------------------------------------
// ram_arbiter_if
// Bundles the signals between the cache-side requesters, the arbiter and the
// RAM model.
//   modport arb : arbiter view (takes requests and RAM status, drives RAM)
//   modport req : requester view (drives requests, sees wait/err/load)
//   modport ram : RAM model view (sees enables/addr/store, drives load/state)
// ----------------------------------------------------------------------------
interface ram_arbiter_if
    import cpu_types_pkg::*;
#(
    parameter int NREQ = 4
);

    logic [NREQ-1:0]       reqREN;
    logic [NREQ-1:0]       reqWEN;
    logic [NREQ-1:0][31:0] reqaddr;
    logic [NREQ-1:0][31:0] reqstore;
    word_t                 reqload;
    logic [NREQ-1:0]       reqwait;
    logic [NREQ-1:0]       reqerr;
    logic                  ramREN;
    logic                  ramWEN;
    word_t                 ramaddr;
    word_t                 ramstore;
    word_t                 ramload;
    ramstate_t             ramstate;

    modport arb (
        input  reqREN, reqWEN, reqaddr, reqstore, ramload, ramstate,
        output reqload, reqwait, reqerr, ramREN, ramWEN, ramaddr, ramstore
    );

    modport req (
        output reqREN, reqWEN, reqaddr, reqstore,
        input  reqload, reqwait, reqerr
    );

    modport ram (
        input  ramREN, ramWEN, ramaddr, ramstore,
        output ramload, ramstate
    );

endinterface

// File: rtl/rr_picker.sv
// ----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin priority encoder. Returns the first set bit of
// `active` when scanning ptr, ptr+1, ... modulo N.
//   active : request vector, one bit per requester
//   ptr    : index that currently has highest priority
//   valid  : at least one request is set
//   index  : chosen requester (0 when valid is low)
// ----------------------------------------------------------------------------
module rr_picker #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  active,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] index
);

    // Walk the offsets from farthest to nearest so the nearest active
    // requester (lowest offset from ptr) is the last one written and wins.
    always_comb begin
        logic [IW-1:0] cand;
        valid = 1'b0;
        index = '0;
        cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr) + k) % N);
            if (active[cand]) begin
                valid = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// ----------------------------------------------------------------------------
// ram_arbiter
// Shares the single RAM port between NREQ cache requesters (0 = core0 icache,
// 1 = core0 dcache, 2 = core1 icache, 3 = core1 dcache) using a registered
// round-robin grant held until ACCESS, ERROR, request withdrawal or timeout.
//   CLK, RST          : clock, synchronous active-high reset
//   reqREN/reqWEN     : per-requester read/write request
//   reqaddr/reqstore  : per-requester address / write data
//   reqload           : broadcast read data (always equals ramload)
//   reqwait           : 0 only for the owner in its completion cycle
//   reqerr            : one-cycle error pulse to the owner
//   ramREN/ramWEN     : RAM enables
//   ramaddr/ramstore  : RAM address / write data
//   ramload/ramstate  : RAM read data / status
// ----------------------------------------------------------------------------
module ram_arbiter
    import cpu_types_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       reqREN,
    input  logic [NREQ-1:0]       reqWEN,
    input  logic [NREQ-1:0][31:0] reqaddr,
    input  logic [NREQ-1:0][31:0] reqstore,
    output logic [31:0]           reqload,
    output logic [NREQ-1:0]       reqwait,
    output logic [NREQ-1:0]       reqerr,
    output logic                  ramREN,
    output logic                  ramWEN,
    output logic [31:0]           ramaddr,
    output logic [31:0]           ramstore,
    input  logic [31:0]           ramload,
    input  ramstate_t             ramstate
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [TW-1:0] TLIMIT = TW'(TIMEOUT);
    localparam logic [IW-1:0] LAST   = IW'(NREQ - 1);

    arb_state_t    state, state_next;
    logic [IW-1:0] owner, owner_next;
    logic [IW-1:0] rr_ptr, rr_ptr_next;
    logic [TW-1:0] tcnt, tcnt_next;

    logic [NREQ-1:0] active;
    logic            pick_valid;
    logic [IW-1:0]   pick_index;
    logic            done_ok, done_err, dropped, release_grant;
    logic [IW-1:0]   owner_plus;

    assign active  = reqREN | reqWEN;
    assign reqload = ramload;

    rr_picker #(.N(NREQ)) u_picker (
        .active (active),
        .ptr    (rr_ptr),
        .valid  (pick_valid),
        .index  (pick_index)
    );

    // ACCESS beats everything; a timeout behaves exactly like ERROR; a
    // withdrawn request only releases when neither of those happened.
    assign done_ok       = (state == OWN) && (ramstate == ACCESS);
    assign done_err      = (state == OWN) && (ramstate != ACCESS)
                           && ((ramstate == ERROR) || (tcnt >= TLIMIT));
    assign dropped       = (state == OWN) && !done_ok && !done_err && !active[owner];
    assign release_grant = done_ok || done_err || dropped;
    assign owner_plus    = (owner == LAST) ? '0 : owner + IW'(1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
            tcnt   <= '0;
        end else begin
            state  <= state_next;
            owner  <= owner_next;
            rr_ptr <= rr_ptr_next;
            tcnt   <= tcnt_next;
        end
    end

    // The busy counter saturates at all-ones so it can never wrap back
    // below TIMEOUT on a very long transaction.
    always_comb begin
        state_next  = state;
        owner_next  = owner;
        rr_ptr_next = rr_ptr;
        tcnt_next   = tcnt;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_next = OWN;
                    owner_next = pick_index;
                    tcnt_next  = '0;
                end
            end
            OWN: begin
                if ((ramstate != ACCESS) && (tcnt != '1)) begin
                    tcnt_next = tcnt + TW'(1);
                end
                if (release_grant) begin
                    state_next  = IDLE;
                    rr_ptr_next = owner_plus;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // RAM side depends only on registered owner and requester inputs, so
    // there is no path from ramstate into ramaddr/ramstore.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        reqwait  = '1;
        reqerr   = '0;
        if (state == OWN) begin
            ramaddr  = reqaddr[owner];
            ramstore = reqstore[owner];
            ramWEN   = reqWEN[owner];
            ramREN   = reqREN[owner] & ~reqWEN[owner];
            if (done_ok) begin
                reqwait[owner] = 1'b0;
            end else if (done_err) begin
                reqwait[owner] = 1'b0;
                reqerr[owner]  = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ram_arbiter
// Self-checking bench for ram_arbiter: directed scenarios plus randomized
// traffic, all compared against a transaction-level reference model.
// ----------------------------------------------------------------------------
module tb_ram_arbiter;
    import cpu_types_pkg::*;

    localparam int NREQ       = 4;
    localparam int TB_TIMEOUT = 4;

    logic                  CLK = 1'b0;
    logic                  RST = 1'b1;
    logic [NREQ-1:0]       reqREN = '0;
    logic [NREQ-1:0]       reqWEN = '0;
    logic [NREQ-1:0][31:0] reqaddr = '0;
    logic [NREQ-1:0][31:0] reqstore = '0;
    word_t                 reqload;
    logic [NREQ-1:0]       reqwait;
    logic [NREQ-1:0]       reqerr;
    logic                  ramREN;
    logic                  ramWEN;
    word_t                 ramaddr;
    word_t                 ramstore;
    word_t                 ramload = '0;
    ramstate_t             ramstate = FREE;

    int compareCount  = 0;
    int mismatchCount = 0;

    // Reference model: who holds the RAM, who has priority next, and how
    // many non-completing cycles the current holder has already used.
    bit modelValid  = 1'b0;
    bit modelBusy   = 1'b0;
    int modelOwner  = 0;
    int modelNext   = 0;
    int modelWaited = 0;

    always #5 CLK = ~CLK;

    ram_arbiter #(.NREQ(NREQ), .TIMEOUT(TB_TIMEOUT)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .reqREN   (reqREN),
        .reqWEN   (reqWEN),
        .reqaddr  (reqaddr),
        .reqstore (reqstore),
        .reqload  (reqload),
        .reqwait  (reqwait),
        .reqerr   (reqerr),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Expected outputs for the current cycle from the model and the inputs.
    task automatic compareModel();
        logic            expREN, expWEN;
        word_t           expAddr, expStore;
        logic [NREQ-1:0] expWait, expErr;
        logic [1:0]      o;
        if (!modelValid) return;
        expREN   = 1'b0;
        expWEN   = 1'b0;
        expAddr  = '0;
        expStore = '0;
        expWait  = '1;
        expErr   = '0;
        o        = modelOwner[1:0];
        if (modelBusy) begin
            expWEN   = reqWEN[o];
            expREN   = reqREN[o] && !reqWEN[o];
            expAddr  = reqaddr[o];
            expStore = reqstore[o];
            if (ramstate == ACCESS) begin
                expWait[o] = 1'b0;
            end else if (ramstate == ERROR || modelWaited >= TB_TIMEOUT) begin
                expWait[o] = 1'b0;
                expErr[o]  = 1'b1;
            end
        end
        checkOutput("model_ramREN",   ramREN,   expREN);
        checkOutput("model_ramWEN",   ramWEN,   expWEN);
        checkOutput("model_ramaddr",  ramaddr,  expAddr);
        checkOutput("model_ramstore", ramstore, expStore);
        checkOutput("model_reqwait",  reqwait,  expWait);
        checkOutput("model_reqerr",   reqerr,   expErr);
        checkOutput("model_reqload",  reqload,  ramload);
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic updateModel();
        bit finished;
        if (RST) begin
            modelValid  = 1'b1;
            modelBusy   = 1'b0;
            modelOwner  = 0;
            modelNext   = 0;
            modelWaited = 0;
        end else if (!modelValid) begin
            return;
        end else if (!modelBusy) begin
            for (int k = 0; k < NREQ; k++) begin
                int i = (modelNext + k) % NREQ;
                if (reqREN[i] || reqWEN[i]) begin
                    modelBusy   = 1'b1;
                    modelOwner  = i;
                    modelWaited = 0;
                    break;
                end
            end
        end else begin
            finished = (ramstate == ACCESS) || (ramstate == ERROR)
                       || (modelWaited >= TB_TIMEOUT)
                       || !(reqREN[modelOwner] || reqWEN[modelOwner]);
            if (finished) begin
                modelBusy = 1'b0;
                modelNext = (modelOwner + 1) % NREQ;
            end else begin
                modelWaited++;
            end
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [NREQ-1:0] ren,
                                 input logic [NREQ-1:0] wen, input ramstate_t rs,
                                 input word_t load);
        @(negedge CLK);
        RST      = rst;
        reqREN   = ren;
        reqWEN   = wen;
        ramstate = rs;
        ramload  = load;
        #1;
        compareModel();
    endtask

    task automatic advanceClock();
        @(posedge CLK);
        updateModel();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        word_t           seen[$];
        logic [NREQ-1:0] ren, wen;
        int              r;
        ramstate_t       rs;

        // Reset state
        applyStimulus(1'b1, '0, '0, FREE, '0);
        advanceClock();
        applyStimulus(1'b0, '0, '0, FREE, '0);
        checkOutput("reset_wait", reqwait, 4'hF);
        checkOutput("reset_err",  reqerr,  4'h0);
        checkOutput("reset_ren",  ramREN,  1'b0);
        checkOutput("reset_addr", ramaddr, 32'h0);
        advanceClock();

        // Reset while requester 1 owns the RAM
        reqaddr[1] = 32'h100;
        applyStimulus(1'b0, 4'b0010, '0, BUSY, '0);
        advanceClock();
        applyStimulus(1'b0, 4'b0010, '0, BUSY, '0);
        checkOutput("midown_ren",  ramREN,  1'b1);
        checkOutput("midown_addr", ramaddr, 32'h100);
        advanceClock();
        applyStimulus(1'b1, 4'b0010, '0, BUSY, '0);
        advanceClock();
        applyStimulus(1'b0, 4'b0010, '0, BUSY, '0);
        checkOutput("rst_ren",  ramREN,  1'b0);
        checkOutput("rst_wait", reqwait, 4'hF);
        advanceClock();
        applyStimulus(1'b0, '0, '0, BUSY, '0);
        advanceClock();
        applyStimulus(1'b0, '0, '0, FREE, '0);
        advanceClock();

        // Single read from requester 2, three BUSY cycles then ACCESS
        reqaddr[2] = 32'h40;
        applyStimulus(1'b0, 4'b0100, '0, FREE, '0);
        advanceClock();
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1'b0, 4'b0100, '0, BUSY, '0);
            checkOutput("rd_addr",      ramaddr, 32'h40);
            checkOutput("rd_wait_busy", reqwait, 4'hF);
            advanceClock();
        end
        applyStimulus(1'b0, 4'b0100, '0, ACCESS, 32'hDEADBEEF);
        checkOutput("rd_wait_done", reqwait, 4'b1011);
        checkOutput("rd_load",      reqload, 32'hDEADBEEF);
        advanceClock();
        applyStimulus(1'b0, '0, '0, FREE, '0);
        advanceClock();

        // All four active, RAM always answers ACCESS: order 0,1,2,3,0
        applyStimulus(1'b1, '0, '0, FREE, '0);
        advanceClock();
        for (int i = 0; i < NREQ; i++) reqaddr[i] = 32'h1000 + 32'(i * 16);
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b0, 4'hF, '0, ACCESS, word_t'(c));
            if (ramREN) seen.push_back(ramaddr);
            advanceClock();
        end
        checkOutput("fair_count", seen.size(), 5);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("fair_grant%0d", i),
                        (i < seen.size()) ? seen[i] : 32'hFFFF_FFFF,
                        32'h1000 + 32'((i % 4) * 16));
        end
        applyStimulus(1'b0, '0, '0, FREE, '0);
        advanceClock();

        // Requester 3 asserts both REN and WEN: treated as a write
        reqaddr[3]  = 32'h80;
        reqstore[3] = 32'h1234;
        applyStimulus(1'b0, 4'b1000, 4'b1000, BUSY, '0);
        advanceClock();
        applyStimulus(1'b0, 4'b1000, 4'b1000, BUSY, '0);
        checkOutput("wr_wen",   ramWEN,   1'b1);
        checkOutput("wr_ren",   ramREN,   1'b0);
        checkOutput("wr_store", ramstore, 32'h1234);
        checkOutput("wr_addr",  ramaddr,  32'h80);
        advanceClock();
        applyStimulus(1'b0, 4'b1000, 4'b1000, ACCESS, '0);
        checkOutput("wr_wait", reqwait, 4'b0111);
        advanceClock();
        applyStimulus(1'b0, '0, '0, FREE, '0);
        advanceClock();

        // Stuck BUSY: error pulse on the fifth OWN cycle, then rr advances
        applyStimulus(1'b1, '0, '0, FREE, '0);
        advanceClock();
        reqaddr[0] = 32'h200;
        reqaddr[1] = 32'h300;
        applyStimulus(1'b0, 4'b0001, '0, BUSY, '0);
        advanceClock();
        for (int n = 1; n <= 5; n++) begin
            applyStimulus(1'b0, 4'b0001, '0, BUSY, '0);
            checkOutput($sformatf("to_err%0d", n), reqerr, (n == 5) ? 4'b0001 : 4'b0000);
            advanceClock();
        end
        applyStimulus(1'b0, 4'b0011, '0, BUSY, '0);
        checkOutput("to_idle_ren", ramREN, 1'b0);
        advanceClock();
        applyStimulus(1'b0, 4'b0011, '0, ACCESS, '0);
        checkOutput("to_rr_addr", ramaddr, 32'h300);
        advanceClock();
        applyStimulus(1'b0, '0, '0, FREE, '0);
        advanceClock();

        // Owner 0 withdraws while BUSY, requester 1 waiting
        applyStimulus(1'b1, '0, '0, FREE, '0);
        advanceClock();
        applyStimulus(1'b0, 4'b0011, '0, BUSY, '0);
        advanceClock();
        applyStimulus(1'b0, 4'b0011, '0, BUSY, '0);
        checkOutput("drop_addr0", ramaddr, 32'h200);
        advanceClock();
        applyStimulus(1'b0, 4'b0010, '0, BUSY, '0);
        checkOutput("drop_ren",  ramREN,  1'b0);
        checkOutput("drop_wait", reqwait, 4'hF);
        checkOutput("drop_err",  reqerr,  4'h0);
        advanceClock();
        applyStimulus(1'b0, 4'b0010, '0, BUSY, '0);
        checkOutput("drop_idle_ren", ramREN, 1'b0);
        advanceClock();
        applyStimulus(1'b0, 4'b0010, '0, ACCESS, '0);
        checkOutput("drop_grant1_ren",  ramREN,  1'b1);
        checkOutput("drop_grant1_addr", ramaddr, 32'h300);
        advanceClock();

        // Randomized traffic with occasional resets
        ren = '0;
        wen = '0;
        for (int c = 0; c < 3000; c++) begin
            #2;
            for (int i = 0; i < NREQ; i++) begin
                reqaddr[i]  = $urandom;
                reqstore[i] = $urandom;
            end
            if ($urandom_range(0, 3) == 0) begin
                ren = 4'($urandom);
                wen = 4'($urandom) & 4'($urandom);
            end
            r  = int'($urandom_range(0, 9));
            rs = (r < 5) ? BUSY : (r < 7) ? ACCESS : (r == 7) ? ERROR : FREE;
            applyStimulus($urandom_range(0, 199) == 0, ren, wen, rs, $urandom);
            advanceClock();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

- Shares the single RAM port between all cache-side requesters of the multicore system: icache and dcache of core 0 and core 1, with `NREQ` = 4.
- Selects one requester with a registered round-robin grant and holds that grant until RAM signals ACCESS, ERROR, request withdrawal or timeout.
- Drives the owner's request onto the RAM port and returns completion to that requester only.
- Sits between the per-core cache controllers and the memory model, below the datapath/cache interfaces.

## Interface
Parameters:
- `NREQ`, 4: number of requesters. Index order: 0 = core0 icache, 1 = core0 dcache, 2 = core1 icache, 3 = core1 dcache.
- `TIMEOUT`, 255: maximum BUSY cycles per transaction before forced release.

Ports (one clock; reset is synchronous and active-high):
- `CLK`  in  1  clock, all state on rising edge.
- `RST`  in  1  synchronous active-high reset.
- `reqREN`  in  NREQ  read request per requester.
- `reqWEN`  in  NREQ  write request per requester.
- `reqaddr`  in  NREQ×32  word_t address per requester.
- `reqstore`  in  NREQ×32  word_t write data per requester.
- `reqload`  out  32  broadcast read data, equals `ramload`.
- `reqwait`  out  NREQ  1 = not complete; 0 only for the owner in its completion cycle.
- `reqerr`  out  NREQ  one-cycle error pulse to the owner.
- `ramREN`  out  1  RAM read enable.
- `ramWEN`  out  1  RAM write enable.
- `ramaddr`  out  32  RAM address.
- `ramstore`  out  32  RAM write data.
- `ramload`  in  32  RAM read data.
- `ramstate`  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.

## Operation
- FSM states: IDLE, OWN.
- Registers:
  - `owner`: clog2(NREQ) bits.
  - `rr_ptr`: clog2(NREQ) bits, the highest-priority index.
  - `tcnt`: 8 bits minimum, sized to hold TIMEOUT.
- Active request: `reqREN[i] | reqWEN[i]`. If both are high, the request is treated as a write.
- IDLE:
  - RAM enables are 0.
  - Every `reqwait` is 1.
  - Pick the first active index scanning `rr_ptr`, `rr_ptr`+1, … modulo NREQ.
  - If one exists: `owner` ← index, `tcnt` ← 0, go to OWN.
- OWN:
  - `ramaddr`/`ramstore` = owner's inputs.
  - `ramWEN` = owner's WEN.
  - `ramREN` = owner's REN & ~WEN.
- OWN exit conditions:
  - `ramstate` == ACCESS: `reqwait[owner]` = 0 in that same cycle. Next cycle: IDLE, `rr_ptr` ← owner+1 (wraps to 0).
  - `ramstate` == ERROR: `reqerr[owner]` = 1 and `reqwait[owner]` = 0 for that cycle. Then IDLE, `rr_ptr` ← owner+1.
  - Owner drops both REN and WEN: RAM enables go to 0 combinationally that cycle; no completion and no error. Next cycle: IDLE, `rr_ptr` ← owner+1.
  - `tcnt` reaches TIMEOUT while `ramstate` ≠ ACCESS: treated exactly as ERROR.
- `tcnt` increments every OWN cycle in which `ramstate` ≠ ACCESS. It saturates and never wraps.
- ACCESS and owner-drop in the same cycle: ACCESS wins, completion is signalled.
- Non-owner requests are ignored (`reqwait` = 1) until re-arbitration.
- `reqload` = `ramload` at all times. It is valid for the owner only in its completion cycle.
- Reset (any cycle, including mid-OWN):
  - state IDLE, `owner` 0, `rr_ptr` 0, `tcnt` 0.
  - Outputs: `ramREN`/`ramWEN` 0, `ramaddr`/`ramstore` 0, `reqwait` all 1, `reqerr` all 0.
  - An in-flight RAM access is abandoned.

## Timing
- Minimum grant latency: a request first seen in IDLE at edge N is driven to RAM in cycle N+1.
- Best case: RAM answers ACCESS in the first OWN cycle, giving a 2-cycle round trip per transaction.
- One dead IDLE cycle between consecutive transactions, for fairness.
- Outputs in OWN are combinational from registered `owner` and requester inputs. Outputs in IDLE are constants.
- No combinational path from `ramstate` to `ramaddr`/`ramstore`.
- With all requesters continuously active, each requester is served at least once every NREQ transactions.

## Structure
- `cpu_types_pkg` already supplies `word_t` and `ramstate_t`.
- Add `arb_state_t` (IDLE, OWN) to `cpu_types_pkg`.
- Add the `ram_arbiter_if` interface file with modports `arb`, `req`, `ram`.
- Natural sub-module: `rr_picker`, a combinational round-robin priority encoder.
  - Inputs: active vector, `rr_ptr`.
  - Outputs: `valid`, `index`.
  - It is reusable for a future coherence-bus arbiter.

## Test plan
- Reset mid-OWN, with requester 1 reading 0x100 and `ramstate` BUSY → next cycle `ramREN` 0, `reqwait` 4'b1111, state IDLE.
- Only requester 2 reads 0x40; `ramstate` BUSY 3 cycles, then ACCESS with `ramload` 0xDEADBEEF → `ramaddr` 0x40 from cycle 1, `reqwait[2]` 0 in the ACCESS cycle, `reqload` 0xDEADBEEF.
- All four requesters held active, RAM always ACCESS → grant order 0,1,2,3,0; each grant is 2 cycles.
- Requester 3 sets REN and WEN with addr 0x80, data 0x1234 → `ramWEN` 1, `ramREN` 0, `ramstore` 0x1234.
- `ramstate` stuck BUSY with TIMEOUT = 4 → `reqerr[owner]` pulses after 4 OWN cycles, then IDLE and `rr_ptr` advanced.
- Owner 0 drops its request while BUSY while requester 1 is active → enables 0 that cycle, then requester 1 is granted 2 cycles later.
